cp0_timer: RTL and testbench
============================

# cp0_timer

Memory-mapped down-counting interval timer that generates the hardware interrupt consumed by the coprocessor-0 interrupt logic. Its `IRQ` output drives `HWInt[2]`, the line CP0 gates with `SR[12]` for interrupt response. Software programs the timer through a three-word register window on the data bus.

## Interface
Parameters:
- `DIV`, default 1. Prescale factor: COUNT decrements once every `DIV` clocks while counting. Legal range is ≥1.

Ports:
- `clk`, in, 1. Single clock; all state changes on the rising edge.
- `reset`, in, 1. Asynchronous, active-low reset.
- `Addr`, in, 30. Word address `[31:2]`; only `Addr[3:2]` is decoded.
- `WE`, in, 1. Write enable for the current bus access.
- `Din`, in, 32. Write data.
- `Dout`, out, 32. Combinational read data for `Addr[3:2]`.
- `IRQ`, out, 1. Interrupt request to CP0 `HWInt[2]`.

## Operation
- Register map by `Addr[3:2]`:
  - 0 is CTRL. bit0 is Enable, bits[2:1] are Mode, bit3 is IM (interrupt mask). Bits[31:4] read as 0.
  - 1 is PRESET, read/write.
  - 2 is COUNT, read-only; writes are ignored.
  - 3 reads 0; writes are ignored.
- Mode 0 is one-shot; Mode 1 is auto-reload. Mode values 2 and 3 behave as Mode 0.
- State machine has four states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable=1, go to LOAD.
  - LOAD: COUNT ← PRESET, prescaler ← 0, go to CNT.
  - CNT: if Enable=0, go to IDLE with COUNT held. Otherwise, on each prescaler tick:
    - if COUNT>1, COUNT ← COUNT−1;
    - else COUNT ← 0, irq_flag ← 1, go to INT.
    - A PRESET of 0 is therefore treated as 1.
  - INT, Mode 0: Enable ← 0, go to IDLE, irq_flag held.
  - INT, Mode 1: irq_flag ← 0, go to LOAD.
- Prescaler counts 0..DIV−1; a tick occurs when it equals DIV−1, then it wraps to 0. With DIV=1 every CNT cycle is a tick.
- irq_flag in Mode 0 clears on any write to CTRL or PRESET.
- `IRQ` = irq_flag & CTRL.IM, evaluated combinationally.
- Writing PRESET during CNT does not change COUNT; the new value takes effect at the next LOAD.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as INT (Mode 0) wins: CTRL takes `Din` and Enable is not forced to 0. FSM still goes to IDLE.
  - A CTRL/PRESET write in the same cycle as the CNT→INT transition leaves irq_flag set; the set has priority over the clear.

## Timing
- Reset (`reset`=0), immediately and asynchronously:
  - CTRL=0, PRESET=0, COUNT=0, prescaler=0, irq_flag=0, state=IDLE.
  - `IRQ`=0; `Dout` reflects the zeroed registers.
  - Reset asserted mid-count aborts with no interrupt.
- Writes take effect at the clock edge where WE=1. Reads are combinational and reflect register state as of the last edge.
- DIV=1, PRESET=N≥1, Enable written at edge t:
  - LOAD at t+1; COUNT=N after t+2.
  - COUNT=N−k after t+2+k for k<N.
  - COUNT=0 and `IRQ`=1 (if IM=1) after t+2+N.
- Mode 1 period: `IRQ` is a one-cycle pulse every N+2 cycles (INT + LOAD + N count cycles).
- Mode 0: `IRQ` stays high until software writes CTRL or PRESET, or reset occurs.
- General DIV: each count step takes DIV cycles. Latency from Enable write to IRQ is 2+N·DIV cycles.
- Clearing Enable during CNT stops the count at the next edge. Re-enabling restarts via LOAD, so COUNT reloads from PRESET.

## Test plan
- **Reset mid-count.** DIV=1, PRESET=5, CTRL=0x9; pulse `reset` low at count 3. Required: COUNT=0 and IRQ=0 immediately; no IRQ afterwards.
- **One-shot.** DIV=1, PRESET=5, CTRL=0x9 (Enable, Mode 0, IM). Required: COUNT reads 5,4,3,2,1,0; IRQ rises 7 cycles after the write and stays high. CTRL reads 0x8 after INT. Writing CTRL=0x8 drops IRQ at the next edge.
- **Auto-reload.** PRESET=3, CTRL=0xB, DIV=1. Required: IRQ is a 1-cycle pulse with exactly 5-cycle spacing, over at least 4 periods.
- **Mask.** Run the one-shot case with CTRL=0x1. Required: COUNT reaches 0 with IRQ=0. Then writing CTRL=0x8 must not raise IRQ, because the write cleared irq_flag.
- **Prescaler.** DIV=4 build, PRESET=2, CTRL=0x9. Required: IRQ is high 2+2·4=10 cycles after the write. PRESET=0 with DIV=1 gives IRQ after 3 cycles.
- **Bus edge cases.**
  - Writing to COUNT or to address 3 changes nothing.
  - A PRESET write during CNT takes effect only on the next Mode 1 reload.
  - Clearing Enable while COUNT=4 holds COUNT at 4 or 3 (depending on the tick in that cycle) with no IRQ.

Source files
------------

// File: rtl/cp0_timer_if.sv
// Data-bus register window between the CPU and the cp0_timer.
// Addr is the word address [31:2]; Dout is combinational read data.
interface cp0_timer_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout
    );
endinterface

// File: rtl/cp0_timer.sv
// Memory-mapped down-counting interval timer driving CP0 HWInt[2].
// CTRL/PRESET/COUNT are reached through a three-word register window.
module cp0_timer #(
    parameter int unsigned DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    cp0_timer_if.slave   bus,
    output logic         IRQ
);

    localparam int unsigned PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam int unsigned EN_BIT = 0;
    localparam int unsigned IM_BIT = 3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [31:0]     preset_q, preset_d;
    logic [31:0]     count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            irq_q, irq_d;

    logic            wr_ctrl;
    logic            wr_preset;
    logic            reload;
    logic            tick;
    logic            unused_addr;

    assign wr_ctrl     = bus.WE && (bus.Addr[1:0] == A_CTRL);
    assign wr_preset   = bus.WE && (bus.Addr[1:0] == A_PRESET);
    assign reload      = (ctrl_q[2:1] == 2'd1);
    assign tick        = (presc_q == PRESC_LAST);
    assign unused_addr = ^bus.Addr[29:2];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            irq_q    <= irq_d;
        end
    end

    // Next state, bus writes and counter update; later assignments take priority
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        presc_d  = presc_q;
        irq_d    = irq_q;

        if (wr_ctrl) begin
            ctrl_d = bus.Din[3:0];
        end
        if (wr_preset) begin
            preset_d = bus.Din;
        end
        // A one-shot interrupt is acknowledged by any CTRL/PRESET write
        if ((wr_ctrl || wr_preset) && !reload) begin
            irq_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ctrl_q[EN_BIT]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                presc_d = '0;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[EN_BIT]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    // COUNT of 0 or 1 both expire here, so PRESET=0 acts as 1
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = '0;
                        irq_d   = 1'b1;
                        state_d = INT;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            INT: begin
                if (reload) begin
                    irq_d   = 1'b0;
                    state_d = LOAD;
                end else begin
                    // A software CTRL write in this cycle keeps its Enable value
                    if (!wr_ctrl) begin
                        ctrl_d[EN_BIT] = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational read mux
    always_comb begin
        bus.Dout = '0;
        case (bus.Addr[1:0])
            A_CTRL:   bus.Dout = {28'd0, ctrl_q};
            A_PRESET: bus.Dout = preset_q;
            A_COUNT:  bus.Dout = count_q;
            default:  bus.Dout = '0;
        endcase
    end

    assign IRQ = irq_q & ctrl_q[IM_BIT];

endmodule

// File: tb/tb_cp0_timer.sv
// Self-checking bench for cp0_timer: directed scenarios plus randomized
// runs against a cycle-count model derived from the timer's timing rules.
module tb_cp0_timer;

    logic clk = 1'b0;
    logic reset;
    logic irq1;
    logic irq4;

    int n_cmp  = 0;
    int n_fail = 0;

    cp0_timer_if b1 ();
    cp0_timer_if b4 ();

    cp0_timer #(.DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .IRQ(irq1));
    cp0_timer #(.DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(b4), .IRQ(irq4));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Expected COUNT m edges after the Enable write (fresh state, m>=2)
    function automatic logic [31:0] exp_count(input int m, input int n, input int div, input bit rl);
        int ne;
        int span;
        int q;
        ne   = (n == 0) ? 1 : n;
        span = ne * div;
        if (m < 2) return 32'd0;
        q = m - 2;
        if (rl) q = q % (span + 2);
        else if (q > span) q = span;
        if (q < div) return 32'(n);
        if (q >= span) return 32'd0;
        return 32'(ne - q / div);
    endfunction

    function automatic logic exp_irq(input int m, input int n, input int div, input bit rl, input bit im);
        int ne;
        int span;
        int q;
        ne   = (n == 0) ? 1 : n;
        span = ne * div;
        if (m < 2) return 1'b0;
        q = m - 2;
        if (rl) return im && ((q % (span + 2)) == span);
        return im && (q >= span);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d4, input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        if (d4) begin
            b4.Addr = 30'(a); b4.Din = v; b4.WE = 1'b1;
        end else begin
            b1.Addr = 30'(a); b1.Din = v; b1.WE = 1'b1;
        end
        @(posedge clk);
        #1;
        b1.WE = 1'b0;
        b4.WE = 1'b0;
    endtask

    task automatic rd(input bit d4, input logic [1:0] a, output logic [31:0] v);
        if (d4) begin
            b4.Addr = 30'(a); #1 v = b4.Dout;
        end else begin
            b1.Addr = 30'(a); #1 v = b1.Dout;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int a = 0; a < 4; a++) begin
            rd(1'b0, 2'(a), v);
            n_cmp++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_dout1[%0d]: got %0h want 0", a, v); end
            rd(1'b1, 2'(a), v);
            n_cmp++;
            if (v !== 32'd0) begin n_fail++; $display("FAIL reset_dout4[%0d]: got %0h want 0", a, v); end
        end
        n_cmp++;
        if (irq1 !== 1'b0 || irq4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b%b want 00", irq1, irq4);
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] v;
        do_reset;
        wr(1'b0, 2'd1, 32'd5);
        wr(1'b0, 2'd0, 32'h9);
        cyc(4);
        rd(1'b0, 2'd2, v);
        n_cmp++;
        if (v !== 32'd3) begin n_fail++; $display("FAIL midrst_pre: got %0d want 3", v); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (b1.Dout !== 32'd0 || irq1 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: got count %0d irq %b want 0 0", b1.Dout, irq1);
        end
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            n_cmp++;
            if (irq1 !== 1'b0) begin n_fail++; $display("FAIL midrst_noirq[%0d]: got %b want 0", i, irq1); end
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic [31:0] e;
        do_reset;
        wr(1'b0, 2'd1, 32'd5);
        wr(1'b0, 2'd0, 32'h9);
        for (int m = 1; m <= 10; m++) begin
            cyc(1);
            rd(1'b0, 2'd2, v);
            e = (m < 2 || m >= 7) ? 32'd0 : 32'(7 - m);
            n_cmp++;
            if (v !== e) begin n_fail++; $display("FAIL oneshot_count[m=%0d]: got %0d want %0d", m, v, e); end
            n_cmp++;
            if (irq1 !== (m >= 7)) begin n_fail++; $display("FAIL oneshot_irq[m=%0d]: got %b want %b", m, irq1, m >= 7); end
        end
        rd(1'b0, 2'd0, v);
        n_cmp++;
        if (v !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl: got %0h want 8", v); end
        wr(1'b0, 2'd0, 32'h8);
        n_cmp++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL oneshot_ack: got %b want 0", irq1); end
    endtask

    task automatic test_mask;
        logic [31:0] v;
        do_reset;
        wr(1'b0, 2'd1, 32'd5);
        wr(1'b0, 2'd0, 32'h1);
        cyc(8);
        rd(1'b0, 2'd2, v);
        n_cmp++;
        if (v !== 32'd0 || irq1 !== 1'b0) begin
            n_fail++; $display("FAIL mask_run: got count %0d irq %b want 0 0", v, irq1);
        end
        wr(1'b0, 2'd0, 32'h8);
        cyc(2);
        n_cmp++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL mask_unmask: got %b want 0", irq1); end
    endtask

    task automatic test_reload;
        int hi[$];
        logic prev;
        do_reset;
        wr(1'b0, 2'd1, 32'd3);
        wr(1'b0, 2'd0, 32'hB);
        prev = 1'b0;
        for (int m = 1; m <= 30; m++) begin
            cyc(1);
            if (irq1 === 1'b1) begin
                hi.push_back(m);
                n_cmp++;
                if (prev === 1'b1) begin n_fail++; $display("FAIL reload_width[m=%0d]: got 2+ cycles want 1", m); end
            end
            prev = irq1;
        end
        n_cmp++;
        if (hi.size() < 5) begin n_fail++; $display("FAIL reload_npulse: got %0d want >=5", hi.size()); end
        if (hi.size() > 0) begin
            n_cmp++;
            if (hi[0] != 5) begin n_fail++; $display("FAIL reload_first: got m=%0d want 5", hi[0]); end
        end
        for (int i = 1; i < hi.size(); i++) begin
            n_cmp++;
            if (hi[i] - hi[i-1] != 5) begin
                n_fail++; $display("FAIL reload_spacing[%0d]: got %0d want 5", i, hi[i] - hi[i-1]);
            end
        end
    endtask

    task automatic test_prescaler;
        do_reset;
        wr(1'b1, 2'd1, 32'd2);
        wr(1'b1, 2'd0, 32'h9);
        for (int m = 1; m <= 11; m++) begin
            cyc(1);
            n_cmp++;
            if (irq4 !== (m >= 10)) begin n_fail++; $display("FAIL presc_div4[m=%0d]: got %b want %b", m, irq4, m >= 10); end
        end
        do_reset;
        wr(1'b0, 2'd1, 32'd0);
        wr(1'b0, 2'd0, 32'h9);
        for (int m = 1; m <= 5; m++) begin
            cyc(1);
            n_cmp++;
            if (irq1 !== (m >= 3)) begin n_fail++; $display("FAIL presc_zero[m=%0d]: got %b want %b", m, irq1, m >= 3); end
        end
    endtask

    task automatic test_bus_edges;
        logic [31:0] v;
        logic [31:0] held;
        bit found;
        do_reset;
        wr(1'b0, 2'd1, 32'd7);
        wr(1'b0, 2'd0, 32'h2);
        wr(1'b0, 2'd2, 32'd123);
        wr(1'b0, 2'd3, 32'd55);
        rd(1'b0, 2'd0, v);
        n_cmp++; if (v !== 32'h2) begin n_fail++; $display("FAIL bus_ctrl: got %0h want 2", v); end
        rd(1'b0, 2'd1, v);
        n_cmp++; if (v !== 32'd7) begin n_fail++; $display("FAIL bus_preset: got %0d want 7", v); end
        rd(1'b0, 2'd2, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL bus_count_ro: got %0d want 0", v); end
        rd(1'b0, 2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_fail++; $display("FAIL bus_addr3: got %0d want 0", v); end

        // PRESET rewrite mid-count applies on the next reload only
        do_reset;
        wr(1'b0, 2'd1, 32'd3);
        wr(1'b0, 2'd0, 32'hB);
        cyc(2);
        wr(1'b0, 2'd1, 32'd6);
        rd(1'b0, 2'd2, v);
        n_cmp++; if (v !== 32'd2) begin n_fail++; $display("FAIL bus_preset_live: got %0d want 2", v); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (irq1 === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL bus_reload_wait: got no irq want irq within 20"); end
        cyc(2);
        rd(1'b0, 2'd2, v);
        n_cmp++; if (v !== 32'd6) begin n_fail++; $display("FAIL bus_reload_val: got %0d want 6", v); end
        cyc(5);
        n_cmp++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL bus_reload_early: got %b want 0", irq1); end
        cyc(1);
        n_cmp++; if (irq1 !== 1'b1) begin n_fail++; $display("FAIL bus_reload_period: got %b want 1", irq1); end

        // Clearing Enable at COUNT=4 freezes the count
        do_reset;
        wr(1'b0, 2'd1, 32'd8);
        wr(1'b0, 2'd0, 32'h9);
        cyc(6);
        rd(1'b0, 2'd2, v);
        n_cmp++; if (v !== 32'd4) begin n_fail++; $display("FAIL stop_pre: got %0d want 4", v); end
        wr(1'b0, 2'd0, 32'h8);
        cyc(1);
        rd(1'b0, 2'd2, held);
        n_cmp++;
        if (held !== 32'd3 && held !== 32'd4) begin n_fail++; $display("FAIL stop_hold: got %0d want 3 or 4", held); end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            rd(1'b0, 2'd2, v);
            n_cmp++;
            if (v !== held || irq1 !== 1'b0) begin
                n_fail++; $display("FAIL stop_frozen[%0d]: got count %0d irq %b want %0d 0", i, v, irq1, held);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        do_reset;
        wr(1'b0, 2'd1, 32'd2);
        wr(1'b0, 2'd0, 32'h9);
        cyc(3);
        wr(1'b0, 2'd1, 32'd2);
        n_cmp++;
        if (irq1 !== 1'b1) begin n_fail++; $display("FAIL b2b_set_wins: got %b want 1", irq1); end
        wr(1'b0, 2'd0, 32'h9);
        rd(1'b0, 2'd0, v);
        n_cmp++;
        if (v !== 32'h9) begin n_fail++; $display("FAIL b2b_ctrl_wins: got %0h want 9", v); end
        n_cmp++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack: got %b want 0", irq1); end
        cyc(3);
        n_cmp++;
        if (irq1 !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_early: got %b want 0", irq1); end
        cyc(1);
        n_cmp++;
        if (irq1 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", irq1); end
    endtask

    task automatic test_random;
        bit          d4;
        bit          im;
        bit          rl;
        int          div;
        int          n;
        int          span;
        int          mmax;
        logic [1:0]  mode;
        logic [31:0] v;
        logic [31:0] ec;
        logic        irq;
        logic        ei;
        for (int it = 0; it < 10; it++) begin
            d4   = 1'($urandom_range(0, 1));
            im   = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 6));
            div  = d4 ? 4 : 1;
            rl   = (mode == 2'd1);
            span = ((n == 0) ? 1 : n) * div;
            mmax = 2 + 2 * (span + 2) + 3;
            do_reset;
            wr(d4, 2'd1, 32'(n));
            wr(d4, 2'd0, {28'd0, im, mode, 1'b1});
            for (int m = 1; m <= mmax; m++) begin
                cyc(1);
                rd(d4, 2'd2, v);
                irq = d4 ? irq4 : irq1;
                ec  = exp_count(m, n, div, rl);
                ei  = exp_irq(m, n, div, rl, im);
                if (m >= 2) begin
                    n_cmp++;
                    if (v !== ec) begin
                        n_fail++;
                        $display("FAIL rand_count[it=%0d m=%0d div=%0d n=%0d mode=%0d]: got %0d want %0d", it, m, div, n, mode, v, ec);
                    end
                end
                n_cmp++;
                if (irq !== ei) begin
                    n_fail++;
                    $display("FAIL rand_irq[it=%0d m=%0d div=%0d n=%0d mode=%0d im=%0d]: got %b want %b", it, m, div, n, mode, im, irq, ei);
                end
            end
        end
    endtask

    initial begin
        b1.Addr = '0; b1.WE = 1'b0; b1.Din = '0;
        b4.Addr = '0; b4.WE = 1'b0; b4.Din = '0;
        reset = 1'b0;
        #12;
        test_reset;
        reset = 1'b1;
        test_reset_midcount;
        test_oneshot;
        test_mask;
        test_reload;
        test_prescaler;
        test_bus_edges;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
